// File: rtl/mul_seq.sv
// mul_seq: iterative shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU, one multiplier bit per clock.
// Latency: 33 edges from start to done; with MULEARLY_EN defined, h+3 edges (h = top set bit of |b|, 2 if |b|=0).
// Backpressure: start is only accepted while busy=0 (including the done cycle); starts while busy are dropped.
module mul_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] a_in,
  input  logic [XLEN-1:0] b_in,
  input  logic [1:0]      op,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] mplier;
  logic [XLEN-1:0] acc_hi;
  logic [1:0]      op_q;
  logic            neg_q;
  logic [CW-1:0]   cnt;

  // Operand conditioning: signed operands enter as magnitudes, sign kept aside.
  logic            sa, sb;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            neg_in;

  always_comb begin
    sa     = (op == 2'b01) || (op == 2'b10);
    sb     = (op == 2'b01);
    a_neg  = sa & a_in[XLEN-1];
    b_neg  = sb & b_in[XLEN-1];
    a_mag  = a_neg ? (~a_in + XLEN'(1)) : a_in;
    b_mag  = b_neg ? (~b_in + XLEN'(1)) : b_in;
    neg_in = a_neg ^ b_neg;
  end

  // One iteration: conditional add into the high half, then shift {c,acc_hi,mplier} right.
  logic [XLEN:0]     sum;
  logic [2*XLEN-1:0] step;
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_fix;

  always_comb begin
    sum      = mplier[0] ? ({1'b0, acc_hi} + {1'b0, mcand}) : {1'b0, acc_hi};
    step     = {sum, mplier[XLEN-1:1]};
    prod     = {acc_hi, mplier};
    prod_fix = neg_q ? (~prod + (2*XLEN)'(1)) : prod;
  end

`ifdef MULEARLY_EN
  // Low XLEN-cnt bits of mplier are the multiplier bits still to be consumed.
  logic [XLEN-1:0]   rem_mask;
  logic              rem_zero;
  logic [CW-1:0]     shamt;
  logic [2*XLEN-1:0] aligned;

  always_comb begin
    rem_mask = {XLEN{1'b1}} >> cnt;
    rem_zero = ((mplier & rem_mask) == '0);
    shamt    = CW'(XLEN) - cnt;
    aligned  = prod >> shamt;
  end
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = CALC;
      end
      CALC: begin
`ifdef MULEARLY_EN
        if (rem_zero) state_nxt = FIX;
`else
        if (cnt == CW'(XLEN - 1)) state_nxt = FIX;
`endif
      end
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc_hi <= '0;
      op_q   <= '0;
      neg_q  <= 1'b0;
      cnt    <= '0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= a_mag;
            mplier <= b_mag;
            acc_hi <= '0;
            op_q   <= op;
            neg_q  <= neg_in;
            cnt    <= '0;
          end
        end
        CALC: begin
`ifdef MULEARLY_EN
          if (rem_zero) begin
            {acc_hi, mplier} <= aligned;
          end else begin
            {acc_hi, mplier} <= step;
            cnt              <= cnt + CW'(1);
          end
`else
          {acc_hi, mplier} <= step;
          cnt              <= cnt + CW'(1);
`endif
        end
        FIX: begin
          result <= (op_q == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: scoreboard bench for mul_seq; a 64-bit arithmetic reference model predicts each result and
// its start-to-done latency, and a negedge monitor pops and compares on every done pulse.
module tb_mul_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks   = 0;
  int failures = 0;
  int edge_cnt = 0;
  logic [31:0] last_res = '0;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          acc_edge;
  } exp_t;

  exp_t sb_q[$];

  mul_seq #(.XLEN(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .a_in   (a_in),
    .b_in   (b_in),
    .op     (op),
    .start  (start),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: extend per signedness to 64 bits and multiply.
  function automatic logic [31:0] model_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint av, bv;
    logic [63:0] p;
    if (o == 2'b01 || o == 2'b10) av = longint'($signed(a));
    else                          av = longint'({32'b0, a});
    if (o == 2'b01)               bv = longint'($signed(b));
    else                          bv = longint'({32'b0, b});
    p = 64'(av * bv);
    return (o == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic int model_lat(input logic [1:0] o, input logic [31:0] b);
`ifdef MULEARLY_EN
    logic [31:0] mb;
    int h;
    mb = (o == 2'b01 && b[31]) ? (32'd0 - b) : b;
    if (mb == 0) return 2;
    h = 0;
    for (int i = 0; i < 32; i++) if (mb[i]) h = i;
    return h + 3;
`else
    return (o == 2'b00 || o != 2'b00) ? 33 : 0;
`endif
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0 result=%h", result);
      end else begin
        e = sb_q.pop_front();
        check("result", result, e.res);
        check("latency", 32'(edge_cnt - e.acc_edge), 32'(e.lat));
        last_res = e.res;
      end
    end
  end

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    check("busy_before_start", {31'b0, busy}, 32'd0);
    op = o; a_in = a; b_in = b; start = 1'b1;
    @(posedge clk);
    #1;
    e.res = model_res(o, a, b);
    e.lat = model_lat(o, b);
    e.acc_edge = edge_cnt;
    sb_q.push_back(e);
    start = 1'b0;
    a_in = $urandom; b_in = $urandom; op = 2'($urandom_range(3));
    check("busy_after_start", {31'b0, busy}, 32'd1);
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout pending=%0d required=0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL wait_done_timeout actual=0 required=1");
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(15));
      default: return 32'($urandom);
    endcase
  endfunction

  logic [1:0]  d_op [6] = '{2'b11, 2'b00, 2'b01, 2'b01, 2'b10, 2'b00};
  logic [31:0] d_a  [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7};
  logic [31:0] d_b  [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFD};

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      issue(d_op[i], d_a[i], d_b[i]);
      drain();
      check("result_hold", result, last_res);
    end

    // Starts while busy must be ignored, then a start in the done cycle is taken.
    issue(2'b11, 32'h1234_5678, 32'h9ABC_DEF1);
    repeat (4) @(negedge clk);
    start = 1'b1; op = 2'b00; a_in = 32'h5555_5555; b_in = 32'h3333_3333;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    start = 1'b1; op = 2'b01; a_in = 32'hAAAA_AAAA; b_in = 32'h7777_7777;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    issue(2'b11, 32'h8000_0000, 32'd4);
    drain();

    // Asynchronous reset in the middle of an operation.
    issue(2'b00, 32'hDEAD_BEEF, 32'hBEEF_CAFE);
    repeat (13) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midreset_busy", {31'b0, busy}, 32'd0);
    check("midreset_done", {31'b0, done}, 32'd0);
    check("midreset_result", result, 32'd0);
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(2'b00, 32'd3, 32'd5);
    drain();

    for (int i = 0; i < 40; i++) begin
      if (sb_q.size() != 0 && $urandom_range(1) == 1) wait_done();
      else drain();
      issue(2'($urandom_range(3)), pick(), pick());
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
